// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ioctl ROM loader: FSM states, file slot
// indices, region decode bit and the default per-file RAM word offsets.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int          WORD_AW             = 17;
    localparam logic [7:0]  IDX_FULL            = 8'd1;
    localparam logic [7:0]  IDX_D               = 8'd2;
    localparam logic [7:0]  IDX_G               = 8'd3;
    localparam int          SPEECH_REGION_BIT   = 18;
    localparam int unsigned HOLD_CYCLES_DEFAULT = 255;
    localparam logic [WORD_AW-1:0] OFS_D_DEFAULT = 17'h01000;
    localparam logic [WORD_AW-1:0] OFS_G_DEFAULT = 17'h0B000;

    function automatic logic [WORD_AW-1:0] region_offset(
        input logic [7:0]         index,
        input logic [WORD_AW-1:0] ofs_d,
        input logic [WORD_AW-1:0] ofs_g
    );
        case (index)
            IDX_D:    region_offset = ofs_d;
            IDX_G:    region_offset = ofs_g;
            IDX_FULL: region_offset = '0;
            default:  region_offset = '0;
        endcase
    endfunction

endpackage

// File: rtl/rom_loader_pack.sv
// Packs the RAM byte stream into 16-bit word writes: pairs even/odd bytes of
// the same word, and flushes a lone even byte as a half-word write.
module rom_loader_pack
    import rom_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               byte_valid,
    input  logic               byte_odd,
    input  logic [WORD_AW-1:0] word_addr,
    input  logic [7:0]         byte_data,
    input  logic               flush_req,
    output logic               ram_we,
    output logic [WORD_AW-1:0] ram_addr,
    output logic [15:0]        ram_data,
    output logic [1:0]         ram_be
);

    logic               pend_reg;
    logic [WORD_AW-1:0] pend_addr_reg;
    logic [7:0]         pend_data_reg;
    logic               defer_reg;
    logic [WORD_AW-1:0] defer_addr_reg;
    logic [7:0]         defer_data_reg;
    logic               we_reg;
    logic [WORD_AW-1:0] addr_reg;
    logic [15:0]        data_reg;
    logic [1:0]         be_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_reg       <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            defer_reg      <= 1'b0;
            defer_addr_reg <= '0;
            defer_data_reg <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            be_reg         <= '0;
        end else begin
            we_reg <= 1'b0;
            if (byte_valid && !byte_odd) begin
                if (pend_reg) begin
                    we_reg   <= 1'b1;
                    addr_reg <= pend_addr_reg;
                    data_reg <= {pend_data_reg, 8'h00};
                    be_reg   <= 2'b10;
                end
                pend_reg      <= 1'b1;
                pend_addr_reg <= word_addr;
                pend_data_reg <= byte_data;
            end else if (byte_valid) begin
                pend_reg <= 1'b0;
                we_reg   <= 1'b1;
                if (pend_reg && pend_addr_reg == word_addr) begin
                    addr_reg <= word_addr;
                    data_reg <= {pend_data_reg, byte_data};
                    be_reg   <= 2'b11;
                end else if (pend_reg) begin
                    // The stale even byte goes out first; the odd byte waits a cycle.
                    addr_reg       <= pend_addr_reg;
                    data_reg       <= {pend_data_reg, 8'h00};
                    be_reg         <= 2'b10;
                    defer_reg      <= 1'b1;
                    defer_addr_reg <= word_addr;
                    defer_data_reg <= byte_data;
                end else begin
                    addr_reg <= word_addr;
                    data_reg <= {8'h00, byte_data};
                    be_reg   <= 2'b01;
                end
            end else if (defer_reg) begin
                defer_reg <= 1'b0;
                we_reg    <= 1'b1;
                addr_reg  <= defer_addr_reg;
                data_reg  <= {8'h00, defer_data_reg};
                be_reg    <= 2'b01;
            end else if (flush_req && pend_reg) begin
                pend_reg <= 1'b0;
                we_reg   <= 1'b1;
                addr_reg <= pend_addr_reg;
                data_reg <= {pend_data_reg, 8'h00};
                be_reg   <= 2'b10;
            end
        end
    end

    assign ram_we   = we_reg;
    assign ram_addr = addr_reg;
    assign ram_data = data_reg;
    assign ram_be   = be_reg;

endmodule

// File: rtl/rom_loader.sv
// ioctl download front end: routes bytes to CPU RAM or speech ROM and drives
// the console hold signals. Optional byte checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned        HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter logic [WORD_AW-1:0] OFS_D       = OFS_D_DEFAULT,
    parameter logic [WORD_AW-1:0] OFS_G       = OFS_G_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               ioctl_download_i,
    input  logic [7:0]         ioctl_index_i,
    input  logic               ioctl_wr_i,
    input  logic [24:0]        ioctl_addr_i,
    input  logic [7:0]         ioctl_dout_i,
    input  logic               reset_req_i,
    output logic               ram_we_o,
    output logic [WORD_AW-1:0] ram_addr_o,
    output logic [15:0]        ram_data_o,
    output logic [1:0]         ram_be_o,
    output logic               speech_we_o,
    output logic [14:0]        speech_addr_o,
    output logic [7:0]         speech_data_o,
    output logic               rom_mask_o,
    output logic               flashloading_o,
    output logic               init_hold_o,
    output logic [15:0]        checksum_o
);

    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   counter_reg, counter_next;
    logic               download_d_reg;
    logic [WORD_AW-1:0] offset_reg;
    logic               rom_mask_reg, init_hold_reg, flashloading_reg;
    logic               speech_we_reg;
    logic [14:0]        speech_addr_reg;
    logic [7:0]         speech_data_reg;

    logic dl_rise, dl_fall, load_entry, accept, speech_sel;

    assign dl_rise    = ioctl_download_i & ~download_d_reg;
    assign dl_fall    = ~ioctl_download_i & download_d_reg;
    assign load_entry = (state_reg != LOAD) && (state_next == LOAD);
    assign accept     = ioctl_wr_i && (state_reg == LOAD);
    assign speech_sel = |ioctl_addr_i[24:SPEECH_REGION_BIT];

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        unique case (state_reg)
            IDLE: begin
                if (dl_rise) begin
                    state_next = LOAD;
                end else if (reset_req_i) begin
                    state_next   = HOLD;
                    counter_next = CNT_LOAD;
                end
            end
            LOAD: begin
                if (dl_fall) state_next = FLUSH;
            end
            FLUSH: begin
                state_next   = HOLD;
                counter_next = CNT_LOAD;
            end
            HOLD: begin
                if (dl_rise) begin
                    state_next = LOAD;
                end else if (reset_req_i) begin
                    counter_next = CNT_LOAD;
                end else if (counter_reg <= CNT_W'(1)) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The edge detector follows the pin even in reset, so a download that is
    // still active when reset releases is not mistaken for a new one.
    always_ff @(posedge clk_i) begin
        download_d_reg <= ioctl_download_i;
        if (!reset_n_i) begin
            state_reg        <= IDLE;
            counter_reg      <= '0;
            offset_reg       <= '0;
            rom_mask_reg     <= 1'b0;
            init_hold_reg    <= 1'b1;
            flashloading_reg <= 1'b1;
            speech_we_reg    <= 1'b0;
            speech_addr_reg  <= '0;
            speech_data_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            counter_reg      <= counter_next;
            flashloading_reg <= (state_next != IDLE);
            if (load_entry) begin
                offset_reg    <= region_offset(ioctl_index_i, OFS_D, OFS_G);
                rom_mask_reg  <= ~ioctl_index_i[0];
                init_hold_reg <= 1'b0;
            end
            speech_we_reg <= accept && speech_sel;
            if (accept && speech_sel) begin
                speech_addr_reg <= ioctl_addr_i[14:0];
                speech_data_reg <= ioctl_dout_i;
            end
        end
    end

    rom_loader_pack u_pack (
        .clk        (clk_i),
        .reset_n    (reset_n_i),
        .byte_valid (accept && !speech_sel),
        .byte_odd   (ioctl_addr_i[0]),
        .word_addr  (ioctl_addr_i[17:1] + offset_reg),
        .byte_data  (ioctl_dout_i),
        .flush_req  (state_reg == FLUSH),
        .ram_we     (ram_we_o),
        .ram_addr   (ram_addr_o),
        .ram_data   (ram_data_o),
        .ram_be     (ram_be_o)
    );

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_reg, checksum_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sum_reg      <= '0;
            checksum_reg <= '0;
        end else begin
            if (load_entry) sum_reg <= '0;
            else if (accept) sum_reg <= sum_reg + {8'h00, ioctl_dout_i};
            if (state_reg == FLUSH) checksum_reg <= sum_reg;
        end
    end

    assign checksum_o = checksum_reg;
`else
    assign checksum_o = '0;
`endif

    assign speech_we_o    = speech_we_reg;
    assign speech_addr_o  = speech_addr_reg;
    assign speech_data_o  = speech_data_reg;
    assign rom_mask_o     = rom_mask_reg;
    assign flashloading_o = flashloading_reg;
    assign init_hold_o    = init_hold_reg;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: word pairing, offsets, speech routing,
// hold timing and reset behaviour, with hand-computed expectations.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        download = 1'b0;
    logic [7:0]  index = 8'd0;
    logic        wr = 1'b0;
    logic [24:0] addr = '0;
    logic [7:0]  dout = '0;
    logic        reset_req = 1'b0;

    logic        ram_we;
    logic [16:0] ram_addr;
    logic [15:0] ram_data;
    logic [1:0]  ram_be;
    logic        speech_we;
    logic [14:0] speech_addr;
    logic [7:0]  speech_data;
    logic        rom_mask, flashloading, init_hold;
    logic [15:0] checksum;

    int vectors = 0;
    int miscompares = 0;
    int wcount = 0;
    int w_base;
    int n;

    rom_loader dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .ioctl_download_i (download),
        .ioctl_index_i    (index),
        .ioctl_wr_i       (wr),
        .ioctl_addr_i     (addr),
        .ioctl_dout_i     (dout),
        .reset_req_i      (reset_req),
        .ram_we_o         (ram_we),
        .ram_addr_o       (ram_addr),
        .ram_data_o       (ram_data),
        .ram_be_o         (ram_be),
        .speech_we_o      (speech_we),
        .speech_addr_o    (speech_addr),
        .speech_data_o    (speech_data),
        .rom_mask_o       (rom_mask),
        .flashloading_o   (flashloading),
        .init_hold_o      (init_hold),
        .checksum_o       (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) wcount <= wcount + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ck(input logic [15:0] v);
`ifdef ROM_LOADER_CHECKSUM_EN
        return v;
`else
        return (v & 16'h0000);
`endif
    endfunction

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; dout = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk);
        index = idx; download = 1'b1;
        @(negedge clk);
    endtask

    // Counts consecutive negedges (starting now) with flashloading high.
    task automatic count_flash(output int cnt);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!flashloading) break;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_write(input string tag, input logic [16:0] a, input logic [1:0] be);
        check({tag, "_we"}, 32'(ram_we), 32'd1);
        check({tag, "_addr"}, 32'(ram_addr), 32'(a));
        check({tag, "_be"}, 32'(ram_be), 32'(be));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_flash", 32'(flashloading), 32'd1);
        check("rst_init_hold", 32'(init_hold), 32'd1);
        check("rst_rom_mask", 32'(rom_mask), 32'd0);
        check("rst_speech_we", 32'(speech_we), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_flash", 32'(flashloading), 32'd0);
        check("idle_init_hold", 32'(init_hold), 32'd1);

        // Index 1: full pair at word 0
        start_dl(8'd1);
        check("l1_init_hold", 32'(init_hold), 32'd0);
        check("l1_flash", 32'(flashloading), 32'd1);
        check("l1_rom_mask", 32'(rom_mask), 32'd0);
        w_base = wcount;
        send_byte(25'h0, 8'h12);
        check("l1_even_nowrite", 32'(ram_we), 32'd0);
        send_byte(25'h1, 8'h34);
        check_write("l1_pair", 17'h00000, 2'b11);
        check("l1_pair_data", 32'(ram_data), 32'h1234);
        download = 1'b0;
        count_flash(n);
        check("l1_flash_len", 32'(n), 32'd257);
        check("l1_wcount", 32'(wcount - w_base), 32'd1);
        check("l1_checksum", 32'(checksum), 32'(ck(16'h0046)));

        // reset_req in IDLE holds for HOLD_CYCLES
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        count_flash(n);
        check("rreq_flash_len", 32'(n), 32'd255);

        // Index 2 (D.bin offset), then index 3 restarted from HOLD
        start_dl(8'd2);
        check("l2_rom_mask", 32'(rom_mask), 32'd1);
        send_byte(25'h2, 8'hAA);
        send_byte(25'h3, 8'hBB);
        check_write("l2_pair", 17'h01001, 2'b11);
        check("l2_pair_data", 32'(ram_data), 32'hAABB);
        download = 1'b0;
        repeat (3) @(negedge clk);
        check("l2_checksum", 32'(checksum), 32'(ck(16'h0165)));
        check("l2_in_hold", 32'(flashloading), 32'd1);
        start_dl(8'd3);
        check("l3_rom_mask", 32'(rom_mask), 32'd0);
        check("l3_flash", 32'(flashloading), 32'd1);
        send_byte(25'h0, 8'h55);
        check("l3_even_nowrite", 32'(ram_we), 32'd0);
        download = 1'b0;
        repeat (2) @(negedge clk);
        check_write("l3_flush", 17'h0B000, 2'b10);
        check("l3_flush_data", 32'(ram_data[15:8]), 32'h55);
        count_flash(n);

        // Index 1: speech routing and pairing corner cases
        start_dl(8'd1);
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        w_base = wcount;
        send_byte(25'h040005, 8'h77);
        check("sp_we", 32'(speech_we), 32'd1);
        check("sp_addr", 32'(speech_addr), 32'h0005);
        check("sp_data", 32'(speech_data), 32'h77);
        check("sp_ram_we", 32'(ram_we), 32'd0);
        send_byte(25'h10, 8'h01);
        send_byte(25'h20, 8'h02);
        check_write("ee_flush", 17'h00008, 2'b10);
        check("ee_flush_data", 32'(ram_data[15:8]), 32'h01);
        send_byte(25'h21, 8'h03);
        check_write("ee_pair", 17'h00010, 2'b11);
        check("ee_pair_data", 32'(ram_data), 32'h0203);
        send_byte(25'h30, 8'h04);
        send_byte(25'h41, 8'h05);
        check_write("mm_flush", 17'h00018, 2'b10);
        check("mm_flush_data", 32'(ram_data[15:8]), 32'h04);
        @(negedge clk);
        check_write("mm_odd", 17'h00020, 2'b01);
        check("mm_odd_data", 32'(ram_data[7:0]), 32'h05);
        download = 1'b0;
        count_flash(n);
        check("mm_wcount", 32'(wcount - w_base), 32'd4);
        check("mm_checksum", 32'(checksum), 32'(ck(16'h0086)));

        // Index 3 offset wraps at 17 bits
        start_dl(8'd3);
        send_byte(25'h3FFFE, 8'h66);
        send_byte(25'h3FFFF, 8'h99);
        check_write("wrap_pair", 17'h0AFFF, 2'b11);
        check("wrap_data", 32'(ram_data), 32'h6699);
        download = 1'b0;
        count_flash(n);

        // Reset mid-download: pending byte lost, bytes ignored until next rise
        start_dl(8'd2);
        send_byte(25'h0, 8'h11);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_init_hold", 32'(init_hold), 32'd1);
        check("mid_rst_flash", 32'(flashloading), 32'd1);
        check("mid_rst_rom_mask", 32'(rom_mask), 32'd0);
        reset_n = 1'b1;
        w_base = wcount;
        send_byte(25'h2, 8'h22);
        send_byte(25'h3, 8'h33);
        send_byte(25'h040001, 8'h44);
        check("post_rst_speech_we", 32'(speech_we), 32'd0);
        check("post_rst_init_hold", 32'(init_hold), 32'd1);
        download = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_wcount", 32'(wcount - w_base), 32'd0);
        start_dl(8'd1);
        check("reload_init_hold", 32'(init_hold), 32'd0);
        send_byte(25'h4, 8'hC1);
        check("reload_even_nowrite", 32'(ram_we), 32'd0);
        send_byte(25'h5, 8'hC2);
        check_write("reload_pair", 17'h00002, 2'b11);
        check("reload_data", 32'(ram_data), 32'hC1C2);
        download = 1'b0;
        count_flash(n);
        check("reload_flash_len", 32'(n), 32'd257);
        check("reload_wcount", 32'(wcount - w_base), 32'd1);
        check("reload_checksum", 32'(checksum), 32'(ck(16'h0183)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
